// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : irq_pkg
//  Description : Shared definitions for the interrupt vector controller:
//                register offsets, line count, the "no interrupt" vector and
//                the priority-encode helper used by the arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package irq_pkg;

   localparam int NUM_IRQ = 15;
   localparam int DATA_W  = 18;

   // Register offsets from BASE_ADRS.
   localparam logic [1:0] IRQ_REG_ENABLE  = 2'd0;
   localparam logic [1:0] IRQ_REG_PENDING = 2'd1;
   localparam logic [1:0] IRQ_REG_ACK     = 2'd2;
   localparam logic [DATA_W-1:0] NUM_REGS = 18'd3;

   localparam logic [3:0] VECTOR_NONE = 4'd0;

   // Only bits 15:1 of ENABLE/PENDING exist; everything else reads zero.
   localparam logic [DATA_W-1:0] REG_MASK = 18'o177776;

   typedef logic [3:0] vector_t;

   // Index of the highest set request line, or VECTOR_NONE when idle.
   // Scans upward so the last (highest) set bit wins.
   function automatic vector_t highest_irq(input logic [NUM_IRQ:1] req);
      vector_t idx;
      idx = VECTOR_NONE;
      for (int i = 1; i <= NUM_IRQ; i++) begin
         if (req[i]) begin
            idx = 4'(i);
         end
      end
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/irq_vector_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : irq_vector_ctrl_if
//  Description : Core port bus as seen by a port-mapped peripheral.
//                port_wr / port_rd : write / read strobes from the core
//                adrs              : 18-bit port address
//                wdata             : write data (core DATAOUT)
//                rdata             : read data back to the core DATAIN mux,
//                                    zero when the peripheral is not selected
//  Revision    : 1.0  initial release
// ============================================================================
interface irq_vector_ctrl_if;
   import irq_pkg::*;

   logic              port_wr;
   logic              port_rd;
   logic [DATA_W-1:0] adrs;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;

   modport master (
      output port_wr,
      output port_rd,
      output adrs,
      output wdata,
      input  rdata
   );

   modport slave (
      input  port_wr,
      input  port_rd,
      input  adrs,
      input  wdata,
      output rdata
   );

endinterface
`default_nettype wire

// File: rtl/irq_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : irq_sync_edge
//  Description : Multi-flop synchroniser for one asynchronous request line
//                followed by a history flop; flags a single-cycle rise when
//                the synchronised level goes 0 -> 1.
//  Ports       : clk, rst_n   clock / asynchronous active-low reset
//                irq_async    raw request line
//                rise         high for one cycle after a synchronised rising edge
//  Parameters  : SYNC_STAGES  synchroniser depth, legal values 2..3
//  Revision    : 1.0  initial release
// ============================================================================
module irq_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic irq_async,
   output logic      rise
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_hist;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
         r_hist <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], irq_async};
         r_hist <= r_sync[SYNC_STAGES-1];
      end
   end

   assign rise = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule
`default_nettype wire

// File: rtl/irq_vector_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : irq_vector_ctrl
//  Description : Interrupt vector controller for Core18. Latches rising edges
//                of 15 request lines as PENDING, masks with ENABLE and
//                presents the highest enabled pending line as VECTOR, locked
//                until software writes ACK.
//  Ports       : clk, rst_n   clock / asynchronous active-low reset
//                irq[15:1]    raw request lines, irq[15] highest priority
//                bus          core port bus (slave side)
//                vector       presented vector, 0 = none
//                irq_active   high while vector != 0
//  Registers   : BASE_ADRS+0 ENABLE  (r/w)
//                BASE_ADRS+1 PENDING (read, write-1-to-clear)
//                BASE_ADRS+2 ACK     (write acknowledges, read returns vector)
//  Revision    : 1.0  initial release
// ============================================================================
module irq_vector_ctrl
   import irq_pkg::*;
#(
   parameter logic [DATA_W-1:0] BASE_ADRS   = 18'o000100,
   parameter int                SYNC_STAGES = 2
) (
   input  wire logic               clk,
   input  wire logic               rst_n,
   input  wire logic [NUM_IRQ:1]   irq,
   irq_vector_ctrl_if.slave        bus,
   output logic      [3:0]         vector,
   output logic                    irq_active
);

   logic [DATA_W-1:0] r_enable;
   logic [DATA_W-1:0] r_pending;
   vector_t           r_vector;
   logic              r_lock;

   logic [NUM_IRQ:1]  w_line_rise;
   logic [DATA_W-1:0] w_rise;
   logic [DATA_W-1:0] w_offset;
   logic              w_hit;
   logic              w_wr_enable;
   logic              w_wr_pending;
   logic              w_ack;
   logic [DATA_W-1:0] w_clear;
   logic [DATA_W-1:0] w_pending_next;
   vector_t           w_winner;

   // ---------------------------------------------------------------------
   // Per-line synchroniser and edge detector
   // ---------------------------------------------------------------------
   for (genvar n = 1; n <= NUM_IRQ; n++) begin : g_irq_line
      irq_sync_edge #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_sync_edge (
         .clk       (clk),
         .rst_n     (rst_n),
         .irq_async (irq[n]),
         .rise      (w_line_rise[n])
      );
   end

   assign w_rise = {2'b00, w_line_rise, 1'b0};

   // ---------------------------------------------------------------------
   // Address decode. The unsigned subtraction wraps addresses below the
   // base to large offsets, so a single compare covers both bounds.
   // ---------------------------------------------------------------------
   assign w_offset     = bus.adrs - BASE_ADRS;
   assign w_hit        = (w_offset < NUM_REGS);
   assign w_wr_enable  = bus.port_wr && w_hit && (w_offset[1:0] == IRQ_REG_ENABLE);
   assign w_wr_pending = bus.port_wr && w_hit && (w_offset[1:0] == IRQ_REG_PENDING);
   // ACK only counts while a vector is locked; with VECTOR = 0 it is inert.
   assign w_ack        = bus.port_wr && w_hit && (w_offset[1:0] == IRQ_REG_ACK) && r_lock;

   // Clear sources: write-1-to-clear and the acknowledged vector's bit.
   always_comb begin
      w_clear = '0;
      if (w_wr_pending) begin
         w_clear = bus.wdata & REG_MASK;
      end
      if (w_ack) begin
         w_clear = w_clear | (18'd1 << r_vector);
      end
   end

   // A fresh edge beats a simultaneous clear of the same line.
   assign w_pending_next = ((r_pending & ~w_clear) | w_rise) & REG_MASK;

   assign w_winner = highest_irq(r_pending[NUM_IRQ:1] & r_enable[NUM_IRQ:1]);

   // ---------------------------------------------------------------------
   // Register file, arbitration and lock
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_enable  <= '0;
         r_pending <= '0;
         r_vector  <= VECTOR_NONE;
         r_lock    <= 1'b0;
      end else begin
         if (w_wr_enable) begin
            r_enable <= bus.wdata & REG_MASK;
         end
         r_pending <= w_pending_next;

         // ACK drops the vector for one cycle; arbitration restarts on the
         // following edge, which guarantees a VECTOR = 0 gap between vectors.
         // A write-1-to-clear of the locked bit leaves the vector in place.
         if (w_ack) begin
            r_vector <= VECTOR_NONE;
            r_lock   <= 1'b0;
         end else if (!r_lock) begin
            r_vector <= w_winner;
            r_lock   <= (w_winner != VECTOR_NONE);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Read mux: zero unless selected, so the core can OR it with others.
   // ---------------------------------------------------------------------
   always_comb begin
      bus.rdata = '0;
      if (bus.port_rd && w_hit) begin
         case (w_offset[1:0])
            IRQ_REG_ENABLE  : bus.rdata = r_enable & REG_MASK;
            IRQ_REG_PENDING : bus.rdata = r_pending & REG_MASK;
            IRQ_REG_ACK     : bus.rdata = {14'd0, r_vector};
            default         : bus.rdata = '0;
         endcase
      end
   end

   assign vector     = r_vector;
   assign irq_active = (r_vector != VECTOR_NONE);

endmodule
`default_nettype wire

// File: tb/tb_irq_vector_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_vector_ctrl
//  Description : Directed self-checking bench for irq_vector_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_irq_vector_ctrl;
   import irq_pkg::*;

   localparam logic [17:0] BASE = 18'o000100;

   logic        clk;
   logic        rst_n;
   logic [15:1] irq;
   logic [3:0]  vector;
   logic        irq_active;

   int n_checks;
   int n_fail;

   irq_vector_ctrl_if bus ();

   irq_vector_ctrl #(
      .BASE_ADRS   (BASE),
      .SYNC_STAGES (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .irq        (irq),
      .bus        (bus.slave),
      .vector     (vector),
      .irq_active (irq_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [17:0] got, input logic [17:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0o expected %0o", tag, got, exp);
      end
   endtask

   // All stimulus and sampling happens 1 time unit after a rising edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_write(input logic [17:0] adrs, input logic [17:0] data);
      bus.port_wr = 1'b1;
      bus.adrs    = adrs;
      bus.wdata   = data;
      tick(1);
      bus.port_wr = 1'b0;
      bus.wdata   = '0;
   endtask

   task automatic bus_read(input logic [17:0] adrs, output logic [17:0] data);
      bus.port_rd = 1'b1;
      bus.adrs    = adrs;
      #1;
      data        = bus.rdata;
      bus.port_rd = 1'b0;
      #1;
   endtask

   logic [17:0] rd;

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      rst_n       = 1'b0;
      irq         = '0;
      bus.port_wr = 1'b0;
      bus.port_rd = 1'b0;
      bus.adrs    = '0;
      bus.wdata   = '0;
      tick(3);
      rst_n = 1'b1;
      tick(2);

      // ---------------- reset state
      bus_read(BASE + 0, rd); check_value("rst_enable", rd, 18'o0);
      bus_read(BASE + 1, rd); check_value("rst_pending", rd, 18'o0);
      check_value("rst_vector", 18'(vector), 18'd0);
      check_value("rst_active", 18'(irq_active), 18'd0);

      // ---------------- latency
      bus_write(BASE + 0, 18'o177776);
      bus_read(BASE + 0, rd); check_value("enable_rb", rd, 18'o177776);
      irq[3] = 1'b1;
      tick(2);
      bus_read(BASE + 1, rd); check_value("lat_pend_e2", rd, 18'o0);
      tick(1);
      bus_read(BASE + 1, rd); check_value("lat_pend_e3", rd, 18'o000010);
      check_value("lat_vec_e3", 18'(vector), 18'd0);
      tick(1);
      check_value("lat_vec_e4", 18'(vector), 18'd3);
      check_value("lat_active", 18'(irq_active), 18'd1);
      bus_read(BASE + 2, rd); check_value("ack_read", rd, 18'd3);

      // ---------------- priority / lock
      irq[9] = 1'b1;
      tick(4);
      check_value("lock_vec", 18'(vector), 18'd3);
      bus_read(BASE + 1, rd); check_value("lock_pend", rd, 18'o001010);
      bus_write(BASE + 2, 18'o0);
      check_value("ack_gap", 18'(vector), 18'd0);
      bus_read(BASE + 1, rd); check_value("ack_pend", rd, 18'o001000);
      tick(1);
      check_value("next_vec", 18'(vector), 18'd9);
      bus_write(BASE + 2, 18'o0);
      tick(3);
      check_value("ack2_vec", 18'(vector), 18'd0);
      bus_read(BASE + 1, rd); check_value("ack2_pend", rd, 18'o0);
      // ACK while unlocked must not disturb anything
      bus_write(BASE + 2, 18'o0);
      bus_read(BASE + 1, rd); check_value("idle_ack", rd, 18'o0);
      irq[3] = 1'b0;
      irq[9] = 1'b0;

      // ---------------- mask
      bus_write(BASE + 0, 18'o0);
      irq[7] = 1'b1;
      tick(2);
      irq[7] = 1'b0;
      tick(3);
      bus_read(BASE + 1, rd); check_value("mask_pend", rd, 18'o000200);
      check_value("mask_vec", 18'(vector), 18'd0);
      bus_write(BASE + 0, 18'o000200);
      check_value("mask_vec_wr", 18'(vector), 18'd0);
      tick(1);
      check_value("mask_vec_on", 18'(vector), 18'd7);
      // clearing the locked bit by write-1 keeps the vector until ACK
      bus_write(BASE + 1, 18'o000200);
      tick(2);
      bus_read(BASE + 1, rd); check_value("w1c_locked_pend", rd, 18'o0);
      check_value("w1c_locked_vec", 18'(vector), 18'd7);
      bus_write(BASE + 2, 18'o0);
      tick(2);
      check_value("mask_ack_vec", 18'(vector), 18'd0);

      // ---------------- collision: capture edge meets write-1-to-clear
      irq[4] = 1'b1;
      tick(2);
      bus_write(BASE + 1, 18'o000020);
      bus_read(BASE + 1, rd); check_value("collide_pend", rd, 18'o000020);
      bus_write(BASE + 1, 18'o000020);
      bus_read(BASE + 1, rd); check_value("w1c_pend", rd, 18'o0);
      irq[4] = 1'b0;

      // ---------------- bus decode
      bus_write(BASE + 0, 18'o777777);
      bus_read(BASE + 0, rd); check_value("enable_mask", rd, 18'o177776);
      bus_read(BASE + 5, rd); check_value("rd_off5", rd, 18'o0);
      bus_read(BASE + 4, rd); check_value("rd_off4", rd, 18'o0);
      bus_read(BASE - 1, rd); check_value("rd_below", rd, 18'o0);
      bus_write(BASE + 3, 18'o0);
      bus_read(BASE + 0, rd); check_value("wr_off3", rd, 18'o177776);
      bus.port_rd = 1'b0;
      bus.adrs    = BASE;
      #1;
      check_value("rd_idle", bus.rdata, 18'o0);

      // ---------------- asynchronous reset drops a presented vector
      irq[5] = 1'b1;
      tick(4);
      check_value("pre_rst_vec", 18'(vector), 18'd5);
      rst_n = 1'b0;
      #1;
      check_value("async_rst_vec", 18'(vector), 18'd0);
      check_value("async_rst_active", 18'(irq_active), 18'd0);
      tick(1);
      rst_n = 1'b1;
      tick(1);
      bus_read(BASE + 0, rd); check_value("post_rst_enable", rd, 18'o0);
      bus_read(BASE + 1, rd); check_value("post_rst_pend", rd, 18'o0);
      irq[5] = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/irq_vector_ctrl.md
Name: irq_vector_ctrl

Overview:
- Interrupt vector controller sitting directly upstream of Core18.
- Collects up to 15 external interrupt request lines, synchronises them and latches rising edges as pending events.
- Applies a software-writable enable mask and presents the highest-priority enabled pending line as the 4-bit VECTOR the core consumes; VECTOR = 0 means no interrupt.
- Software configures, inspects and acknowledges it through the core's port bus (PORT_WR/PORT_RD/ADRS/DATAOUT).

Parameters:
- BASE_ADRS, 18'o000100, port address of register 0; the block decodes BASE_ADRS+0..+2.
- SYNC_STAGES, 2, synchroniser flops per IRQ line; legal values 2..3.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- IRQ  in  15 [15:1]  raw request lines, asynchronous to CLK; IRQ[15] has highest priority.
- PORT_WR  in  1  core port write strobe.
- PORT_RD  in  1  core port read strobe.
- ADRS  in  18  core port address.
- WDATA  in  18  write data, wired to core DATAOUT.
- RDATA  out  18  read data to the core DATAIN mux; all-zero when not selected, so it can be OR-combined.
- VECTOR  out  4  presented vector, 0 = none.
- IRQ_ACTIVE  out  1  high while VECTOR != 0.

Behaviour:
- Reset (RESET_N low, asynchronous): synchroniser flops, edge-history flops, ENABLE, PENDING, lock flag and VECTOR all clear to 0. IRQ_ACTIVE = 0. RDATA = 0.
  - Release of reset takes effect at the next CLK edge.
  - Reset asserted mid-operation drops any presented vector immediately; a request whose edge was lost is not recovered.
- Register map (bits 15:1 meaningful; bits 17:16 and 0 read 0 and ignore writes):
  - +0 ENABLE: read/write.
  - +1 PENDING: read; writing 1 to a bit clears it, writing 0 leaves it unchanged.
  - +2 ACK: write of any data clears PENDING[VECTOR] and releases the lock; reads return {14'b0, VECTOR}.
- Edge capture: each IRQ line passes through SYNC_STAGES flops plus one history flop. A rising edge (synced=1, history=0) sets PENDING[n] on the following edge.
  - Latency, SYNC_STAGES=2: counting edge 1 as the first CLK edge that samples IRQ[n] high, PENDING[n]=1 after edge 3 and VECTOR updates after edge 4.
  - A level held high sets PENDING once only.
  - Pulses shorter than one CLK period may be missed; this is a documented limitation.
- Priority and lock:
  - Unlocked: on each edge, VECTOR <= index of the highest set bit of (PENDING & ENABLE), or 0 if none.
  - When VECTOR becomes non-zero, the lock sets. While locked, VECTOR holds even if a higher-priority request arrives or ENABLE is changed.
  - ACK write: clears PENDING[VECTOR] and the lock in the same edge. VECTOR re-evaluates on the next edge (one cycle of VECTOR = 0 minimum between successive vectors).
  - ACK while unlocked (VECTOR = 0): no effect.
- Simultaneous events:
  - A new edge on line n in the same cycle as a clear of n (write-1 to PENDING or ACK): the set wins and PENDING[n] stays 1.
  - Write-1-to-clear of the bit currently locked in VECTOR: PENDING clears but VECTOR and the lock hold until ACK.
  - Write to ENABLE: affects arbitration from the next edge.
- RDATA: combinational. Equals the selected register when PORT_RD=1 and ADRS is in BASE_ADRS..+2, else 0. Reads have no side effects.
- Writes take effect on the CLK edge where PORT_WR=1 and ADRS matches. Unmatched addresses are ignored.

Decomposition:
- Shared package irq_pkg holds:
  - offsets IRQ_REG_ENABLE=0, IRQ_REG_PENDING=1, IRQ_REG_ACK=2;
  - NUM_IRQ=15;
  - VECTOR_NONE=4'd0.
- One sub-module, irq_sync_edge: parameterised SYNC_STAGES synchroniser plus rising-edge detector, instantiated per line via generate.
- Priority encoder, lock and register file stay in irq_vector_ctrl.

Test Plan:
- Reset: after RESET_N low then high, ENABLE=0, PENDING=0, VECTOR=0, IRQ_ACTIVE=0. Assert RESET_N low while VECTOR=5 -> VECTOR=0 immediately, without waiting for CLK.
- Latency: write ENABLE=18'o177776, raise IRQ[3] -> PENDING reads 18'o000010 after edge 3, VECTOR=3 after edge 4. Holding IRQ[3] high after ACK -> no second event.
- Priority/lock: with VECTOR=3 locked, raise IRQ[9] -> VECTOR stays 3. Write ACK -> VECTOR=0 for one cycle, then 9. ACK again -> VECTOR=0, PENDING=0.
- Mask: ENABLE=0, pulse IRQ[7] -> PENDING bit 7 set, VECTOR=0. Write ENABLE bit 7 -> VECTOR=7 on the next edge.
- Collision: time IRQ[4]'s capture edge to coincide with a PENDING write of 18'o000020 -> PENDING[4] remains 1.
- Bus: read ADRS=BASE_ADRS+5 -> RDATA=0. Write ENABLE with 18'o777777 -> reads back 18'o177776. PORT_RD=0 -> RDATA=0.
